async_fifo: RTL and testbench

ASYNC_FIFO -- requirements
Module: async_fifo

---
 rtl/async_fifo.sv | 63 ++++++
 tb/tb_async_fifo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/async_fifo.sv
// Single-clock 8-bit FIFO (rd_clk kept for port compatibility only); registered rdata, 1-cycle read latency.
// No backpressure: a write when full or a read when empty is dropped and flagged by a one-cycle overflow/underflow pulse.
module async_fifo #(
   parameter int fifo_depth   = 8,
   parameter int address_size = 4
) (
   input  logic       wr_clk,
   input  logic       rd_clk,
   input  logic       rst,
   input  logic       wr,
   input  logic       rd,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       valid,
   output logic       empty,
   output logic       full,
   output logic       overflow,
   output logic       underflow
);
   localparam int AW = address_size - 1;
   localparam logic [address_size-1:0] PTR_ONE = {{(address_size-1){1'b0}}, 1'b1};

   logic [7:0]              mem [fifo_depth];
   logic [address_size-1:0] wptr;
   logic [address_size-1:0] rptr;
   logic                    wr_ok;
   logic                    rd_ok;
   logic                    unused_rd_clk;

   assign unused_rd_clk = rd_clk;

   // The MSB is the wrap bit: equal low bits with differing wrap bits means one full lap ahead.
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign wr_ok = wr && !full;
   assign rd_ok = rd && !empty;

   always_ff @(posedge wr_clk) begin
      if (wr_ok)
         mem[wptr[AW-1:0]] <= wdata;
   end

   always_ff @(posedge wr_clk or posedge rst) begin
      if (rst) begin
         wptr      <= '0;
         rptr      <= '0;
         rdata     <= 8'h00;
         valid     <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_ok)
            wptr <= wptr + PTR_ONE;
         if (rd_ok) begin
            rptr  <= rptr + PTR_ONE;
            rdata <= mem[rptr[AW-1:0]];
         end
         valid     <= rd_ok;
         overflow  <= wr && full;
         underflow <= rd && empty;
      end
   end
endmodule

// File: tb/tb_async_fifo.sv
// Bench for async_fifo: per-scenario tasks driving stimulus with a queue scoreboard of written words.
module tb_async_fifo;
   localparam int DEPTH = 8;

   logic       wr_clk;
   logic       rd_clk;
   logic       rst;
   logic       wr;
   logic       rd;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       valid;
   logic       empty;
   logic       full;
   logic       overflow;
   logic       underflow;

   typedef struct {
      logic       w;
      logic       r;
      logic [7:0] d;
   } step_t;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] sb[$];
   logic       exp_valid;
   logic       exp_ovf;
   logic       exp_udf;
   logic [7:0] exp_rdata;

   async_fifo #(.fifo_depth(DEPTH), .address_size(4)) dut (
      .wr_clk(wr_clk), .rd_clk(rd_clk), .rst(rst), .wr(wr), .rd(rd), .wdata(wdata),
      .rdata(rdata), .valid(valid), .empty(empty), .full(full),
      .overflow(overflow), .underflow(underflow)
   );

   initial begin
      wr_clk = 1'b0;
      forever #5 wr_clk = ~wr_clk;
   end
   assign rd_clk = wr_clk;

   // Drives one cycle and updates the reference model; outputs are sampled 1 ns after the edge.
   task automatic drive(input logic w, input logic r, input logic [7:0] d);
      int n = sb.size();
      wr = w;
      rd = r;
      wdata = d;
      exp_ovf   = w && (n == DEPTH);
      exp_udf   = r && (n == 0);
      exp_valid = r && (n != 0);
      if (w && n != DEPTH)
         sb.push_back(d);
      @(posedge wr_clk);
      #1;
      wr = 1'b0;
      rd = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wr = 1'b0;
      rd = 1'b0;
      wdata = 8'h00;
      exp_rdata = 8'h00;
      #20;
      rst = 1'b0;
      #1;
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset.empty got=%b exp=1", empty); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL reset.full got=%b exp=0", full); end
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset.valid got=%b exp=0", valid); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset.overflow got=%b exp=0", overflow); end
      total++; if (underflow !== 1'b0) begin bad++; $display("FAIL reset.underflow got=%b exp=0", underflow); end
      total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset.rdata got=%h exp=00", rdata); end
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 9; i++) begin
         drive(1'b1, 1'b0, 8'(i));
         total++; if (full !== (i >= 8)) begin bad++; $display("FAIL fill.full w%0d got=%b exp=%b", i, full, (i >= 8)); end
         total++; if (empty !== 1'b0) begin bad++; $display("FAIL fill.empty w%0d got=%b exp=0", i, empty); end
         total++; if (overflow !== (i == 9)) begin bad++; $display("FAIL fill.overflow w%0d got=%b exp=%b", i, overflow, (i == 9)); end
         total++; if (valid !== 1'b0) begin bad++; $display("FAIL fill.valid w%0d got=%b exp=0", i, valid); end
      end
      drive(1'b0, 1'b0, 8'h00);
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill.overflow_clear got=%b exp=0", overflow); end
      total++; if (full !== 1'b1) begin bad++; $display("FAIL fill.full_hold got=%b exp=1", full); end
   endtask

   task automatic test_drain();
      for (int i = 1; i <= 9; i++) begin
         drive(1'b0, 1'b1, 8'h00);
         if (exp_valid)
            exp_rdata = sb.pop_front();
         total++; if (valid !== (i <= 8)) begin bad++; $display("FAIL drain.valid r%0d got=%b exp=%b", i, valid, (i <= 8)); end
         total++; if (rdata !== 8'((i <= 8) ? i : 8)) begin bad++; $display("FAIL drain.rdata r%0d got=%0d exp=%0d", i, rdata, (i <= 8) ? i : 8); end
         total++; if (rdata !== exp_rdata) begin bad++; $display("FAIL drain.scoreboard r%0d got=%0d exp=%0d", i, rdata, exp_rdata); end
         total++; if (underflow !== (i == 9)) begin bad++; $display("FAIL drain.underflow r%0d got=%b exp=%b", i, underflow, (i == 9)); end
         total++; if (empty !== (i >= 8)) begin bad++; $display("FAIL drain.empty r%0d got=%b exp=%b", i, empty, (i >= 8)); end
      end
      drive(1'b0, 1'b0, 8'h00);
      total++; if (underflow !== 1'b0) begin bad++; $display("FAIL drain.underflow_clear got=%b exp=0", underflow); end
   endtask

   task automatic test_wrap();
      step_t st[$];
      for (int i = 1; i <= 8; i++) st.push_back('{1'b1, 1'b0, 8'(i)});
      for (int i = 0; i < 4; i++)  st.push_back('{1'b0, 1'b1, 8'h00});
      for (int i = 9; i <= 12; i++) st.push_back('{1'b1, 1'b0, 8'(i)});
      for (int i = 0; i < 8; i++)  st.push_back('{1'b0, 1'b1, 8'h00});
      foreach (st[k]) begin
         drive(st[k].w, st[k].r, st[k].d);
         if (exp_valid)
            exp_rdata = sb.pop_front();
         total++; if (valid !== exp_valid) begin bad++; $display("FAIL wrap.valid step%0d got=%b exp=%b", k, valid, exp_valid); end
         total++; if (rdata !== exp_rdata) begin bad++; $display("FAIL wrap.rdata step%0d got=%0d exp=%0d", k, rdata, exp_rdata); end
         total++; if ({overflow, underflow} !== {exp_ovf, exp_udf}) begin bad++; $display("FAIL wrap.flags step%0d got=%b%b exp=%b%b", k, overflow, underflow, exp_ovf, exp_udf); end
         total++; if ({empty, full} !== {sb.size() == 0, sb.size() == DEPTH}) begin bad++; $display("FAIL wrap.empty_full step%0d got=%b%b exp=%b%b", k, empty, full, sb.size() == 0, sb.size() == DEPTH); end
      end
      total++; if (rdata !== 8'd12) begin bad++; $display("FAIL wrap.last got=%0d exp=12", rdata); end
   endtask

   task automatic test_back_to_back();
      step_t st[$];
      for (int i = 0; i < 3; i++) st.push_back('{1'b1, 1'b0, 8'(20 + i)});
      for (int i = 0; i < 5; i++) st.push_back('{1'b1, 1'b1, 8'(30 + i)});
      foreach (st[k]) begin
         drive(st[k].w, st[k].r, st[k].d);
         if (exp_valid)
            exp_rdata = sb.pop_front();
         total++; if (valid !== exp_valid) begin bad++; $display("FAIL b2b.valid step%0d got=%b exp=%b", k, valid, exp_valid); end
         total++; if (rdata !== exp_rdata) begin bad++; $display("FAIL b2b.rdata step%0d got=%0d exp=%0d", k, rdata, exp_rdata); end
         total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL b2b.flags step%0d got=%b%b exp=00", k, overflow, underflow); end
         total++; if ({empty, full} !== 2'b00) begin bad++; $display("FAIL b2b.empty_full step%0d got=%b%b exp=00", k, empty, full); end
      end
      total++; if (sb.size() != 3) begin bad++; $display("FAIL b2b.occupancy got=%0d exp=3", sb.size()); end
   endtask

   task automatic test_full_empty_rw();
      step_t st[$];
      for (int i = 0; i < 5; i++) st.push_back('{1'b1, 1'b0, 8'(40 + i)});
      st.push_back('{1'b1, 1'b1, 8'd99});
      for (int i = 0; i < 7; i++) st.push_back('{1'b0, 1'b1, 8'h00});
      st.push_back('{1'b1, 1'b1, 8'h55});
      for (int i = 0; i < 4; i++) st.push_back('{1'b1, 1'b0, 8'(60 + i)});
      foreach (st[k]) begin
         drive(st[k].w, st[k].r, st[k].d);
         if (exp_valid)
            exp_rdata = sb.pop_front();
         total++; if (valid !== exp_valid) begin bad++; $display("FAIL rw.valid step%0d got=%b exp=%b", k, valid, exp_valid); end
         total++; if (rdata !== exp_rdata) begin bad++; $display("FAIL rw.rdata step%0d got=%0d exp=%0d", k, rdata, exp_rdata); end
         total++; if ({overflow, underflow} !== {exp_ovf, exp_udf}) begin bad++; $display("FAIL rw.flags step%0d got=%b%b exp=%b%b", k, overflow, underflow, exp_ovf, exp_udf); end
         total++; if ({empty, full} !== {sb.size() == 0, sb.size() == DEPTH}) begin bad++; $display("FAIL rw.empty_full step%0d got=%b%b exp=%b%b", k, empty, full, sb.size() == 0, sb.size() == DEPTH); end
      end
      total++; if (sb.size() != 5) begin bad++; $display("FAIL rw.occupancy got=%0d exp=5", sb.size()); end
   endtask

   task automatic test_mid_reset();
      #3;
      rst = 1'b1;
      #1;
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL midrst.empty got=%b exp=1", empty); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL midrst.full got=%b exp=0", full); end
      total++; if ({valid, overflow, underflow} !== 3'b000) begin bad++; $display("FAIL midrst.pulses got=%b%b%b exp=000", valid, overflow, underflow); end
      total++; if (rdata !== 8'h00) begin bad++; $display("FAIL midrst.rdata got=%h exp=00", rdata); end
      #2;
      rst = 1'b0;
      sb.delete();
      exp_rdata = 8'h00;
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 8'h00);
         total++; if (underflow !== 1'b1) begin bad++; $display("FAIL midrst.underflow r%0d got=%b exp=1", i, underflow); end
         total++; if (valid !== 1'b0) begin bad++; $display("FAIL midrst.valid r%0d got=%b exp=0", i, valid); end
         total++; if (empty !== 1'b1) begin bad++; $display("FAIL midrst.empty_after r%0d got=%b exp=1", i, empty); end
      end
      drive(1'b1, 1'b0, 8'd77);
      drive(1'b0, 1'b1, 8'h00);
      if (exp_valid)
         exp_rdata = sb.pop_front();
      total++; if (valid !== 1'b1) begin bad++; $display("FAIL midrst.resume_valid got=%b exp=1", valid); end
      total++; if (rdata !== exp_rdata) begin bad++; $display("FAIL midrst.resume_rdata got=%0d exp=%0d", rdata, exp_rdata); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_back_to_back();
      test_full_empty_rw();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
